// File: rtl/delay_tap_reader.sv
// Read-side tap engine for the audio delay buffer: one slewed, wrapped BRAM read per sample strobe.
// Samples whose tap reaches past the written history come out as silence.
module delay_tap_reader #(
    parameter int unsigned RAM_DEPTH    = 48000,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned INIT_DELAY   = 24000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        audio_valid_in,
    input  logic [15:0] write_addr_in,
    input  logic        wrote_in,
    input  logic [15:0] delay_target_in,
    output logic [15:0] ram_addr_out,
    input  logic [15:0] ram_data_in,
    output logic [15:0] sample_out,
    output logic        sample_valid_out,
    output logic [15:0] delay_current_out,
    output logic        busy_out,
    output logic        overrun_out
);

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   wait_cnt, wait_d;
    logic [AW-1:0]   addr_d, sample_d, delay_d, fill_q;
    logic            valid_d, busy_d, overrun_d;
    logic [AW-1:0]   tgt_c, step_c, addr_c;
    logic [AW:0]     diff_c;

    // Clamp the requested delay into 1..RAM_DEPTH-1 and take one slew step toward it
    always_comb begin
        tgt_c = delay_target_in;
        if (delay_target_in == '0)
            tgt_c = AW'(1);
        else if (32'(delay_target_in) >= RAM_DEPTH)
            tgt_c = AW'(RAM_DEPTH - 1);

        step_c = delay_current_out;
        if (delay_current_out < tgt_c)
            step_c = AW'(delay_current_out + AW'(1));
        else if (delay_current_out > tgt_c)
            step_c = AW'(delay_current_out - AW'(1));

        diff_c = {1'b0, write_addr_in} - {1'b0, step_c};
        addr_c = diff_c[AW] ? AW'(diff_c + (AW+1)'(RAM_DEPTH)) : diff_c[AW-1:0];
    end

    always_comb begin
        state_d   = state;
        wait_d    = wait_cnt;
        addr_d    = ram_addr_out;
        sample_d  = sample_out;
        delay_d   = delay_current_out;
        valid_d   = 1'b0;
        overrun_d = overrun_out;

        case (state)
            IDLE: begin
                if (audio_valid_in) begin
                    delay_d = step_c;
                    addr_d  = addr_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (READ_LATENCY <= 1) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                    wait_d  = CW'(READ_LATENCY - 2);
                end
            end
            WAIT: begin
                if (wait_cnt == '0)
                    state_d = CAPTURE;
                else
                    wait_d = CW'(wait_cnt - CW'(1));
            end
            CAPTURE: begin
                sample_d = (fill_q >= delay_current_out) ? ram_data_in : '0;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe landing on an in-flight read is dropped and flagged
        if (audio_valid_in && (state != IDLE))
            overrun_d = 1'b1;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            ram_addr_out      <= '0;
            sample_out        <= '0;
            sample_valid_out  <= 1'b0;
            delay_current_out <= AW'(INIT_DELAY);
            busy_out          <= 1'b0;
            overrun_out       <= 1'b0;
        end else begin
            state             <= state_d;
            wait_cnt          <= wait_d;
            ram_addr_out      <= addr_d;
            sample_out        <= sample_d;
            sample_valid_out  <= valid_d;
            delay_current_out <= delay_d;
            busy_out          <= busy_d;
            overrun_out       <= overrun_d;
        end
    end

    // Count of committed samples, saturating once the buffer has been filled once
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            fill_q <= '0;
        else if (wrote_in && (32'(fill_q) < RAM_DEPTH))
            fill_q <= AW'(fill_q + AW'(1));
    end

endmodule
